// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate BIST controller.
// Response bit order is {NOT2, NOT1, OR2, OR1, AND2, AND1}.
package gate_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int RESP_W      = 6;

  localparam int AND1 = 0;
  localparam int AND2 = 1;
  localparam int OR1  = 2;
  localparam int OR2  = 3;
  localparam int NOT1 = 4;
  localparam int NOT2 = 5;

  function automatic logic [2:0] popcnt_resp(input logic [RESP_W-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < RESP_W; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/gate_bist_golden.sv
// Expected response of the six gates under test for a given stimulus pair.
module gate_bist_golden
  import gate_bist_pkg::*;
(
  input  logic              a_i,
  input  logic              b_i,
  output logic [RESP_W-1:0] exp_o
);

  always_comb begin
    exp_o       = '0;
    exp_o[AND1] = a_i & b_i;
    exp_o[AND2] = a_i & b_i;
    exp_o[OR1]  = a_i | b_i;
    exp_o[OR2]  = a_i | b_i;
    exp_o[NOT1] = ~a_i;
    exp_o[NOT2] = ~a_i;
  end

endmodule

// File: rtl/gate_bist.sv
// Gate BIST sequencer: walks 4 vectors, waits to settle, checks 6 gate responses.
// Define GATE_BIST_LOOP_EN to rerun clean passes continuously.
//
// state   | meaning
// IDLE    | waiting for start after reset
// DRIVE   | a/b driven with current vector, settle counter loaded
// SETTLE  | settle counter running down, a/b stable
// CHECK   | responses compared, fail_map/err_cnt updated
// DONE    | pass finished, results held until next start
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [RESP_W-1:0] resp_i,
  output logic              a_o,
  output logic              b_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [RESP_W-1:0] fail_map_o,
  output logic [ERR_W-1:0]  err_cnt_o
);

  localparam int               SUM_W     = ERR_W + 3;
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [1:0]       VI_LAST   = 2'(NUM_VECTORS - 1);

  state_t            state_q;
  logic [1:0]        vi_q;
  logic [3:0]        cnt_q;
  logic              a_q, b_q, busy_q, done_q;
  logic [RESP_W-1:0] fail_map_q, fail_map_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [RESP_W-1:0] exp_resp, mismatch;
  logic [SUM_W-1:0]  err_sum;

  gate_bist_golden u_golden (
    .a_i  (a_q),
    .b_i  (b_q),
    .exp_o(exp_resp)
  );

  always_comb begin
    mismatch   = resp_i ^ exp_resp;
    fail_map_d = fail_map_q | mismatch;
    err_sum    = SUM_W'(err_cnt_q) + SUM_W'(popcnt_resp(mismatch));
    err_cnt_d  = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      vi_q       <= '0;
      cnt_q      <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_map_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q    <= ST_DRIVE;
            vi_q       <= '0;
            {a_q, b_q} <= 2'b00;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            fail_map_q <= '0;
            err_cnt_q  <= '0;
          end
        end
        ST_DRIVE: begin
          state_q <= ST_SETTLE;
          cnt_q   <= SETTLE_LD;
          done_q  <= 1'b0;
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_q <= ST_CHECK;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        ST_CHECK: begin
          fail_map_q <= fail_map_d;
          err_cnt_q  <= err_cnt_d;
          if (vi_q != VI_LAST) begin
            state_q    <= ST_DRIVE;
            vi_q       <= vi_q + 2'd1;
            {a_q, b_q} <= vi_q + 2'd1;
          end else begin
`ifdef GATE_BIST_LOOP_EN
            if (fail_map_d == '0) begin
              // clean pass: restart immediately, flag it with a one-cycle done
              state_q    <= ST_DRIVE;
              vi_q       <= '0;
              {a_q, b_q} <= 2'b00;
              fail_map_q <= '0;
              err_cnt_q  <= '0;
              done_q     <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
`else
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a_o        = a_q;
  assign b_o        = b_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign fail_map_o = fail_map_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench for gate_bist: pass-position model compared every cycle
// plus literal checks of the characteristic fault scenarios.
module tb_gate_bist;
  import gate_bist_pkg::*;

  localparam int S        = 2;
  localparam int ERR_W    = 8;
  localparam int PER_VEC  = S + 2;
  localparam int PASS_LEN = NUM_VECTORS * PER_VEC;
  localparam int ERR_SAT  = (1 << ERR_W) - 1;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic a, b, busy, done;
  logic [5:0] resp, fail_map;
  logic [ERR_W-1:0] err_cnt;
  logic [5:0] sa0 = '0, sa1 = '0, inv = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_bist #(.SETTLE_CYCLES(S), .ERR_W(ERR_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .resp_i(resp),
    .a_o(a), .b_o(b), .busy_o(busy), .done_o(done),
    .fail_map_o(fail_map), .err_cnt_o(err_cnt)
  );

  function automatic logic [5:0] golden(input logic x, input logic y);
    return {~x, ~x, x | y, x | y, x & y, x & y};
  endfunction

  function automatic logic [5:0] faulty(input logic [5:0] g, input logic [5:0] s0,
                                        input logic [5:0] s1, input logic [5:0] iv);
    return ((g & ~s0) | s1) ^ iv;
  endfunction

  assign resp = faulty(golden(a, b), sa0, sa1, inv);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position within the pass, accumulated results
  bit         m_run   = 0;
  int         m_pos   = 0;
  logic [5:0] m_fail  = '0;
  int         m_err   = 0;
  bit         m_pulse = 0;

  always @(posedge clk or posedge rst) begin
    int v;
    logic [5:0] g, mm;
    if (rst) begin
      m_run = 0; m_pos = 0; m_fail = '0; m_err = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if ((!m_run || m_pos >= PASS_LEN) && start) begin
        m_run = 1; m_pos = 0; m_fail = '0; m_err = 0;
      end else if (m_run && m_pos < PASS_LEN) begin
        if (m_pos % PER_VEC == PER_VEC - 1) begin
          v  = m_pos / PER_VEC;
          g  = golden(v[1], v[0]);
          mm = faulty(g, sa0, sa1, inv) ^ g;
          m_fail = m_fail | mm;
          m_err  = m_err + $countones(mm);
          if (m_err > ERR_SAT) m_err = ERR_SAT;
        end
        m_pos++;
`ifdef GATE_BIST_LOOP_EN
        if (m_pos == PASS_LEN && m_fail == '0) begin
          m_pos = 0; m_err = 0; m_pulse = 1;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    int v;
    logic [31:0] ea, eb, ebusy, edone, efail, eerr;
    if (rst || !m_run) begin
      ea = 0; eb = 0; ebusy = 0; edone = 0; efail = 0; eerr = 0;
    end else if (m_pos < PASS_LEN) begin
      v = m_pos / PER_VEC;
      ea = 32'((v >> 1) & 1); eb = 32'(v & 1);
      ebusy = 1; edone = 32'(m_pulse);
      efail = 32'(m_fail); eerr = 32'(m_err);
    end else begin
      ea = 1; eb = 1; ebusy = 0; edone = 1;
      efail = 32'(m_fail); eerr = 32'(m_err);
    end
    chk("a", 32'(a), ea);
    chk("b", 32'(b), eb);
    chk("busy", 32'(busy), ebusy);
    chk("done", 32'(done), edone);
    chk("fail_map", 32'(fail_map), efail);
    chk("err_cnt", 32'(err_cnt), eerr);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles from the current point until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin tick(); n++; end
    if (n >= 100) chk("done_timeout", 32'(n), 32'(PASS_LEN));
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_fail", 32'(fail_map), 0);

`ifdef GATE_BIST_LOOP_EN
    pulse_start();
    wait_done(n);
    chk("loop_first_len", 32'(n), 32'(PASS_LEN));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("loop_pulse_width", 32'(done), 0);
      wait_done(n);
      chk("loop_period", 32'(n + 1), 32'(PASS_LEN));
    end
    sa0 = 6'b000100;
    tick();
    wait_done(n);
    chk("loop_fault_len", 32'(n + 1), 32'(PASS_LEN));
    chk("loop_fault_map", 32'(fail_map), 32'(6'b000100));
    chk("loop_fault_err", 32'(err_cnt), 3);
    tick(5);
    chk("loop_stays_done", 32'(done), 1);
    chk("loop_stays_busy", 32'(busy), 0);
`else
    pulse_start();
    wait_done(n);
    chk("clean_len", 32'(n), 32'(PASS_LEN));
    chk("clean_map", 32'(fail_map), 0);
    chk("clean_err", 32'(err_cnt), 0);

    sa1 = 6'b000010;
    pulse_start();
    wait_done(n);
    chk("and2_sa1_map", 32'(fail_map), 32'(6'b000010));
    chk("and2_sa1_err", 32'(err_cnt), 3);

    sa1 = '0; inv = 6'b010000;
    pulse_start();
    wait_done(n);
    chk("not1_inv_map", 32'(fail_map), 32'(6'b010000));
    chk("not1_inv_err", 32'(err_cnt), 4);
    tick(3);
    chk("done_hold_map", 32'(fail_map), 32'(6'b010000));
    chk("done_hold_ab", 32'({a, b}), 3);

    inv = '0; sa1 = 6'b000010;
    pulse_start();
    tick(9);
    chk("pre_rst_map", 32'(fail_map), 32'(6'b000010));
    rst = 1'b1;
    #1;
    chk("rst_outs", 32'({a, b, busy, done, fail_map, err_cnt}), 0);
    tick();
    rst = 1'b0; sa1 = '0;
    tick();
    pulse_start();
    wait_done(n);
    chk("post_rst_len", 32'(n), 32'(PASS_LEN));
    chk("post_rst_map", 32'(fail_map), 0);

    pulse_start();
    tick(7);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("restart_ignored_len", 32'(n + 8), 32'(PASS_LEN));

    for (int it = 0; it < 30; it++) begin
      sa0 = (it % 4 == 0) ? '0 : 6'($urandom & $urandom & $urandom);
      sa1 = (it % 4 == 0) ? '0 : 6'($urandom & $urandom & $urandom);
      inv = (it % 4 == 0) ? '0 : 6'($urandom & $urandom & $urandom);
      pulse_start();
      for (int c = 0; c < PASS_LEN + 4; c++) begin
        start = ($urandom_range(7) == 0);
        rst   = ($urandom_range(49) == 0);
        tick();
      end
      start = 1'b0; rst = 1'b0;
      tick($urandom_range(3));
    end
    sa0 = '0; sa1 = '0; inv = '0;
    tick(PASS_LEN + 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles waited after driving each vector before sampling responses; legal range 1..15.
REQ-002 Parameter ERR_W, default 8: width of the mismatch counter.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a test pass; sampled only in IDLE or DONE.
REQ-006 a, b  output  1 each  stimulus bits driven to the gate instances under test.
REQ-007 resp  input  6  responses, bit order {onot2, onot1, oor2, oor1, oand2, oand1}.
REQ-008 busy  output  1  high from the cycle after start is accepted until the DONE entry cycle.
REQ-009 done  output  1  high while in DONE.
REQ-010 fail_map  output  6  sticky per-gate mismatch flags, same bit order as resp.
REQ-011 err_cnt  output  ERR_W  total mismatching response bits in the current pass, saturating.

Function
REQ-012 States: IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-013 IDLE/DONE + start -> DRIVE; vector index vi cleared to 0, fail_map and err_cnt cleared on the same edge.
REQ-014 DRIVE: {a,b} = vi (a = vi[1], b = vi[0]); unconditional -> SETTLE; settle counter loaded with SETTLE_CYCLES-1.
REQ-015 SETTLE: counter decrements each cycle; at 0 -> CHECK; a/b held stable.
REQ-016 CHECK: resp compared in one cycle against golden {~a, ~a, a|b, a|b, a&b, a&b}.
REQ-017 CHECK: each mismatching bit ORs into fail_map; err_cnt += popcount(mismatch), saturating at 2^ERR_W-1.
REQ-018 CHECK with vi < 3: vi increments -> DRIVE; vi == 3 -> DONE.
REQ-019 Vector order 00, 01, 10, 11; a full pass takes 4*(SETTLE_CYCLES+2) cycles from start acceptance to DONE entry.
REQ-020 start during DRIVE/SETTLE/CHECK is ignored; no restart mid-pass.
REQ-021 a and b hold their last-driven value in DONE; they are 0 in IDLE.
REQ-022 fail_map and err_cnt remain stable in DONE until the next accepted start.

Reset
REQ-023 rst asserted at any time, including mid-pass, forces IDLE immediately; a=0, b=0, busy=0, done=0, fail_map=0, err_cnt=0, vi=0, settle counter=0.
REQ-024 First start is accepted no earlier than the first rising edge after rst deasserts.

Configuration
REQ-025 Macro GATE_BIST_LOOP_EN.
REQ-026 Defined: on reaching the DONE condition with fail_map == 0, the block returns to DRIVE with vi=0 and counters cleared, running continuously; done pulses for one cycle per clean pass; any failing pass stops in DONE.
REQ-027 Not defined: the block always stops in DONE after one pass (REQ-018).

Structure
REQ-028 Package gate_bist_pkg: state enum, NUM_VECTORS=4, RESP_W=6, resp bit index constants (AND1..NOT2).
REQ-029 Sub-module gate_bist_golden: combinational a,b -> 6-bit expected response; the only sub-module.

Verification
REQ-030 Correct gates, SETTLE_CYCLES=2, start pulse -> done after 16 cycles, fail_map=6'b000000, err_cnt=0.
REQ-031 oand2 stuck-at-1 -> fail_map=6'b000010, err_cnt=3 (mismatches on vectors 00, 01, 10).
REQ-032 onot1 inverted (buffer) -> fail_map=6'b010000, err_cnt=4.
REQ-033 rst pulsed during SETTLE of vector 2 -> all outputs 0 and state IDLE immediately; new start gives a full clean pass.
REQ-034 start re-pulsed during CHECK -> ignored; pass length unchanged at 16 cycles.
REQ-035 GATE_BIST_LOOP_EN defined, correct gates -> done pulses every 16 cycles; inject oor1 stuck-at-0 -> stops in DONE with fail_map=6'b000100, err_cnt=3.
